// File: rtl/vfd_grid_capture.sv
`default_nettype none
// ============================================================================
// Module   : vfd_grid_capture
// Purpose  : Rebuilds a stable per-grid frame buffer from the multiplexed VFD
//            grid strobes and segment drives produced by the MCU output ports.
//            A row is only rewritten once its strobe and segment pattern have
//            held unchanged for SETTLE clocks, so transient port states that
//            appear between successive port-write instructions never reach
//            the frame buffer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NGRID   number of grid strobes (one frame-buffer row per grid)
//   NSEG    segment bits per row
//   SETTLE  clocks grid/segments must stay unchanged before a row latch (>=1)
//   DECAY   clocks without refresh before a row blanks (VFD_DECAY_EN only)
// Ports
//   clk      in   system clock (same as MCU clock)
//   reset    in   synchronous, active-high
//   grid_in  in   [NGRID] grid strobes, active-high
//   seg_in   in   [NSEG]  segment drives, active-high
//   rd_row   in   [RW]    row select for read-out
//   rd_data  out  [NSEG]  frame-buffer row[rd_row], combinational, 0 if out of range
//   row_lit  out  [NGRID] bit n set when row n holds non-zero segments
//   upd      out  one-clock pulse, one clock after any row write/blank
//   upd_row  out  [RW]    lowest row index touched in the reported cycle
// Configuration
//   VFD_DECAY_EN  when defined, every row blanks after DECAY clocks without
//                 a rewrite; otherwise rows hold until rewritten or reset.
// ============================================================================
module vfd_grid_capture #(
    parameter int NGRID  = 8,
    parameter int NSEG   = 19,
    parameter int SETTLE = 16,
`ifdef VFD_DECAY_EN
    parameter int DECAY  = 65535,
`endif
    localparam int RW    = (NGRID > 1) ? $clog2(NGRID) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NGRID-1:0] grid_in,
    input  logic [NSEG-1:0]  seg_in,
    input  logic [RW-1:0]    rd_row,
    output logic [NSEG-1:0]  rd_data,
    output logic [NGRID-1:0] row_lit,
    output logic             upd,
    output logic [RW-1:0]    upd_row
);

    localparam int            CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] c_SETTLE = CW'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_LATCH  = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [NGRID-1:0]        r_grid_q;
    logic [NSEG-1:0]         r_seg_q;
    logic [CW-1:0]           r_scnt;
    logic                    r_evt_any;
    logic [RW-1:0]           r_evt_row;

    logic                    w_change;
    logic [CW-1:0]           w_scnt_next;
    logic [NGRID-1:0]        w_wr_en;
    logic [NGRID-1:0]        w_evt;
    logic [RW-1:0]           w_low;
    logic [NGRID-1:0][NSEG-1:0] w_rows;

    // The counter clears on the same edge the registered copy takes a new
    // value, so r_scnt is the number of clocks grid_q/seg_q have held.
    assign w_change = (grid_in != r_grid_q) || (seg_in != r_seg_q);

    always_comb begin
        w_scnt_next = r_scnt;
        if (w_change) begin
            w_scnt_next = '0;
        end else if (r_scnt != c_SETTLE) begin
            w_scnt_next = r_scnt + 1'b1;
        end
    end

    assign w_wr_en = (r_state == S_LATCH) ? r_grid_q : '0;

    // Lowest index among rows written or blanked this clock.
    always_comb begin
        w_low = '0;
        for (int i = NGRID - 1; i >= 0; i--) begin
            if (w_evt[i]) begin
                w_low = RW'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Input registers, stability counter, control FSM, update pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grid_q  <= '0;
            r_seg_q   <= '0;
            r_scnt    <= '0;
            r_state   <= S_IDLE;
            r_evt_any <= 1'b0;
            r_evt_row <= '0;
            upd       <= 1'b0;
            upd_row   <= '0;
        end else begin
            r_grid_q  <= grid_in;
            r_seg_q   <= seg_in;
            r_scnt    <= w_scnt_next;

            // Row events are staged once so upd lands one clock after the write.
            r_evt_any <= |w_evt;
            r_evt_row <= w_low;
            upd       <= r_evt_any;
            if (r_evt_any) begin
                upd_row <= r_evt_row;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_grid_q != '0) begin
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_grid_q == '0) begin
                        r_state <= S_IDLE;
                    end else if (w_scnt_next == c_SETTLE) begin
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    // A zero counter in HOLD means the inputs just moved.
                    if (r_grid_q == '0) begin
                        r_state <= S_IDLE;
                    end else if (r_scnt == '0) begin
                        r_state <= S_SETTLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame-buffer rows
    // ------------------------------------------------------------------------
    for (genvar n = 0; n < NGRID; n++) begin : g_row
        logic [NSEG-1:0] r_row;

`ifdef VFD_DECAY_EN
        localparam int            DW      = $clog2(DECAY + 1);
        localparam logic [DW-1:0] c_DECAY = DW'(DECAY);

        logic [DW-1:0] r_dcnt;
        logic          w_decay_hit;

        // Counter steps 1 -> 0 on this clock: the row blanks now.
        assign w_decay_hit = (r_dcnt == DW'(1));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_row  <= '0;
                r_dcnt <= '0;
            end else if (w_wr_en[n]) begin
                // A fresh write takes priority over a coincident decay.
                r_row  <= r_seg_q;
                r_dcnt <= c_DECAY;
            end else begin
                if (r_dcnt != '0) begin
                    r_dcnt <= r_dcnt - 1'b1;
                end
                if (w_decay_hit) begin
                    r_row <= '0;
                end
            end
        end

        assign w_evt[n] = w_wr_en[n] | w_decay_hit;
`else
        always_ff @(posedge clk) begin
            if (reset) begin
                r_row <= '0;
            end else if (w_wr_en[n]) begin
                r_row <= r_seg_q;
            end
        end

        assign w_evt[n] = w_wr_en[n];
`endif

        assign w_rows[n]  = r_row;
        assign row_lit[n] = |r_row;
    end

    // Asynchronous read; rows beyond NGRID read as zero.
    always_comb begin
        rd_data = '0;
        if (int'(rd_row) < NGRID) begin
            rd_data = w_rows[rd_row];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vfd_grid_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_vfd_grid_capture
// Purpose  : Self-checking bench for vfd_grid_capture. Expected update events
//            (row index and clock number) are queued when stimulus is driven
//            and matched against every upd pulse the design produces.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vfd_grid_capture;

    localparam int c_SETTLE = 16;
    localparam int c_DECAY  = 65535;

    logic        clk;
    logic        reset;
    logic [7:0]  grid_in;
    logic [18:0] seg_in;
    logic [2:0]  rd_row;
    logic [18:0] rd_data;
    logic [7:0]  row_lit;
    logic        upd;
    logic [2:0]  upd_row;

    typedef struct {
        int row;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_vec;
    int   n_miscmp;

    vfd_grid_capture dut (
        .clk     (clk),
        .reset   (reset),
        .grid_in (grid_in),
        .seg_in  (seg_in),
        .rd_row  (rd_row),
        .rd_data (rd_data),
        .row_lit (row_lit),
        .upd     (upd),
        .upd_row (upd_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (clk %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive new inputs just after a rising edge; cyc then holds that edge's number.
    task automatic drive(input logic [7:0] g, input logic [18:0] s);
        @(posedge clk);
        #1;
        grid_in = g;
        seg_in  = s;
    endtask

    // Queue an update expected SETTLE+3 clocks after the drive edge (plus extra).
    task automatic expect_upd(input int row, input int extra);
        exp_t e;
        e.row = row;
        e.cyc = cyc + c_SETTLE + 3 + extra;
        sb.push_back(e);
    endtask

    task automatic check_row(input string tag, input int r, input logic [18:0] exp);
        @(negedge clk);
        rd_row = 3'(r);
        #1;
        check_val(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic check_lit(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check_val(tag, 32'(row_lit), 32'(exp));
    endtask

    // Scoreboard consumer: every upd pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (upd) begin
            if (sb.size() == 0) begin
                check_val("upd_unexpected", 32'(upd), 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("upd_row", 32'(upd_row), 32'(e.row));
                check_val("upd_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        reset    = 1'b1;
        grid_in  = '0;
        seg_in   = '0;
        rd_row   = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check_val("rst_upd", 32'(upd), 32'd0);
        check_val("rst_upd_row", 32'(upd_row), 32'd0);
        check_lit("rst_row_lit", 8'h00);
        for (int r = 0; r < 8; r++) check_row("rst_row", r, 19'h0);

        // Single grid latched after settling
        drive(8'h01, 19'h155AA);
        expect_upd(0, 0);
`ifdef VFD_DECAY_EN
        // Write lands at drive+SETTLE+2; blank DECAY clocks later, upd one after.
        expect_upd(0, c_DECAY);
`endif
        repeat (20) @(posedge clk);
        check_row("s1_row0", 0, 19'h155AA);
        check_row("s1_row1", 1, 19'h0);
        check_lit("s1_row_lit", 8'h01);

        // Grids off for a long time
        drive(8'h00, 19'h0);
        repeat (70000) @(posedge clk);
`ifdef VFD_DECAY_EN
        check_row("s4_row0_decayed", 0, 19'h0);
        check_lit("s4_row_lit", 8'h00);
`else
        check_row("s4_row0_kept", 0, 19'h155AA);
        check_lit("s4_row_lit", 8'h01);
`endif

        // Segments toggling every clock never settle
        drive(8'h04, 19'h00001);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 seg_in = (seg_in == 19'h00001) ? 19'h00002 : 19'h00001;
        end
        drive(8'h00, 19'h0);
        check_row("s2_row2", 2, 19'h0);

        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Two grids together: both written, one update reporting the lower row
        drive(8'h12, 19'h7FFFF);
        expect_upd(1, 0);
        repeat (20) @(posedge clk);
        check_row("s3_row1", 1, 19'h7FFFF);
        check_row("s3_row4", 4, 19'h7FFFF);
        check_row("s3_row0", 0, 19'h0);
        check_lit("s3_row_lit", 8'h12);

        // Segment change during HOLD re-settles and rewrites the same grid
        drive(8'h08, 19'h00011);
        expect_upd(3, 0);
        repeat (20) @(posedge clk);
        check_row("s6_row3_first", 3, 19'h00011);
        drive(8'h08, 19'h00022);
        expect_upd(3, 0);
        repeat (c_SETTLE + 1) @(posedge clk);
        check_row("s6_row3_old_during_write", 3, 19'h00011);
        check_row("s6_row3_new", 3, 19'h00022);
        check_row("s6_row1_kept", 1, 19'h7FFFF);
        check_lit("s6_row_lit", 8'h1A);

        // Reset mid-settle cancels the pending write
        drive(8'h80, 19'h00F0F);
        repeat (11) @(posedge clk);
        #1;
        reset   = 1'b1;
        grid_in = '0;
        seg_in  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        for (int r = 0; r < 8; r++) check_row("s5_row", r, 19'h0);
        check_lit("s5_row_lit", 8'h00);
        check_val("s5_upd", 32'(upd), 32'd0);

        check_val("sb_pending", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire
